// File: rtl/seq_lock.sv
// seq_lock: switch-sequence combination lock.
// The user presses and releases switch patterns in order; a step counts only
// when its pattern is released back to all-zero. Any other nonzero pattern
// sends the lock to ERR, and each entry into ERR bumps a saturating fail count.
// Optional feature macro: SEQ_LOCK_TIMEOUT_EN adds an inter-step inactivity
// timeout of TIMEOUT_CYC cycles that forces ERR.
module seq_lock #(
  parameter int unsigned SW_W        = 4,
  parameter int unsigned SEQ_LEN     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SW_W-1:0]             sw,
  input  logic [SEQ_LEN*SW_W-1:0]     code,
  input  logic                        clr,
  output logic                        unlocked,
  output logic                        err,
  output logic [$clog2(SEQ_LEN)-1:0]  step,
  output logic [3:0]                  fail_cnt
);

  localparam int unsigned STEP_W = $clog2(SEQ_LEN);

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_HELD  = 2'd1,
    ST_OPEN  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  state_t             r_state;
  logic [STEP_W-1:0]  r_step;
  logic               r_unlocked;
  logic               r_err;
  logic [3:0]         r_fail_cnt;

  logic [SW_W-1:0]    r_sw_meta;
  logic [SW_W-1:0]    r_sw_s;

  logic [SW_W-1:0]    w_code_cur;
  logic               w_sw_zero;
  logic               w_sw_match;
  logic               w_timeout;
  logic               w_bad;
  logic [3:0]         w_fail_inc;

  // Two-flop synchroniser for the raw switch levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta <= '0;
      r_sw_s    <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_s    <= r_sw_meta;
    end
  end

  // Pattern for the awaited step; an all-zero pattern can never match
  assign w_code_cur = code[int'(r_step)*SW_W +: SW_W];
  assign w_sw_zero  = (r_sw_s == '0);
  assign w_sw_match = !w_sw_zero && (r_sw_s == w_code_cur);
  assign w_bad      = w_timeout || (!w_sw_zero && !w_sw_match);
  assign w_fail_inc = (r_fail_cnt == 4'hF) ? r_fail_cnt : r_fail_cnt + 4'd1;

`ifdef SEQ_LOCK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_tmo_run;
  logic             w_stay;

  assign w_tmo_run = ((r_state == ST_ARMED) && (r_step != '0)) || (r_state == ST_HELD);
  assign w_timeout = w_tmo_run && (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  // FSM holds both state and step this cycle
  assign w_stay    = !w_timeout &&
                     (((r_state == ST_ARMED) && w_sw_zero) ||
                      ((r_state == ST_HELD) && w_sw_match));

  // Inactivity counter: counts while waiting mid-sequence, restarts on any move
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (clr) begin
      r_tmo_cnt <= '0;
    end else if (w_tmo_run && w_stay) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Lock FSM with registered outputs; clr overrides every transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ARMED;
      r_step     <= '0;
      r_unlocked <= 1'b0;
      r_err      <= 1'b0;
      r_fail_cnt <= '0;
    end else if (clr) begin
      r_state    <= ST_ARMED;
      r_step     <= '0;
      r_unlocked <= 1'b0;
      r_err      <= 1'b0;
      r_fail_cnt <= '0;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_bad) begin
            r_state    <= ST_ERR;
            r_err      <= 1'b1;
            r_fail_cnt <= w_fail_inc;
          end else if (w_sw_match) begin
            r_state <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (w_bad) begin
            r_state    <= ST_ERR;
            r_err      <= 1'b1;
            r_fail_cnt <= w_fail_inc;
          end else if (w_sw_zero) begin
            if (r_step == STEP_W'(SEQ_LEN - 1)) begin
              r_state    <= ST_OPEN;
              r_unlocked <= 1'b1;
            end else begin
              r_state <= ST_ARMED;
              r_step  <= r_step + STEP_W'(1);
            end
          end
        end
        ST_OPEN: begin
          r_state <= ST_OPEN;
        end
        ST_ERR: begin
          if (w_sw_zero) begin
            r_state <= ST_ARMED;
            r_step  <= '0;
            r_err   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign unlocked = r_unlocked;
  assign err      = r_err;
  assign step     = r_step;
  assign fail_cnt = r_fail_cnt;

endmodule

// File: tb/tb_seq_lock.sv
// tb_seq_lock: directed table-driven bench for seq_lock
// (SW_W=4, SEQ_LEN=3, TIMEOUT_CYC=16, code steps 0001, 0010, 0100).
module tb_seq_lock;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sw;
  logic [11:0] code;
  logic        clr;
  logic        unlocked;
  logic        err;
  logic [1:0]  step;
  logic [3:0]  fail_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] sw;
    logic       clr;
    int         ncyc;
    logic       ul;
    logic       er;
    logic [1:0] st;
    logic [3:0] fc;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  seq_lock #(
    .SW_W       (4),
    .SEQ_LEN    (3),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw      (sw),
    .code    (code),
    .clr     (clr),
    .unlocked(unlocked),
    .err     (err),
    .step    (step),
    .fail_cnt(fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic ul, input logic er,
                     input logic [1:0] st, input logic [3:0] fc);
    n_checks++;
    if ({unlocked, err, step, fail_cnt} !== {ul, er, st, fc}) begin
      n_errors++;
      $display("FAIL %s got ul=%0b err=%0b step=%0d fail=%0d expected ul=%0b err=%0b step=%0d fail=%0d",
               name, unlocked, err, step, fail_cnt, ul, er, st, fc);
    end
  endtask

  // One press/release of a pattern: held 5 edges, released 3 edges
  task automatic do_step(input logic [3:0] p);
    sw = p;
    tick(5);
    sw = 4'b0000;
    tick(3);
  endtask

  initial begin
    int exp_fc;

    // press pattern, clr, edges to run, then expected ul, err, step, fail
    vecs[0]  = '{4'b0001, 1'b0, 5, 1'b0, 1'b0, 2'd0, 4'd0};
    vecs[1]  = '{4'b0000, 1'b0, 3, 1'b0, 1'b0, 2'd1, 4'd0};
    vecs[2]  = '{4'b0010, 1'b0, 5, 1'b0, 1'b0, 2'd1, 4'd0};
    vecs[3]  = '{4'b0000, 1'b0, 3, 1'b0, 1'b0, 2'd2, 4'd0};
    vecs[4]  = '{4'b0100, 1'b0, 5, 1'b0, 1'b0, 2'd2, 4'd0};
    vecs[5]  = '{4'b0000, 1'b0, 2, 1'b0, 1'b0, 2'd2, 4'd0};
    vecs[6]  = '{4'b0000, 1'b0, 1, 1'b1, 1'b0, 2'd2, 4'd0};
    vecs[7]  = '{4'b1000, 1'b0, 5, 1'b1, 1'b0, 2'd2, 4'd0};
    vecs[8]  = '{4'b0000, 1'b0, 3, 1'b1, 1'b0, 2'd2, 4'd0};
    vecs[9]  = '{4'b0000, 1'b1, 1, 1'b0, 1'b0, 2'd0, 4'd0};
    vecs[10] = '{4'b0000, 1'b0, 3, 1'b0, 1'b0, 2'd0, 4'd0};
    vecs[11] = '{4'b0001, 1'b0, 5, 1'b0, 1'b0, 2'd0, 4'd0};
    vecs[12] = '{4'b0000, 1'b0, 3, 1'b0, 1'b0, 2'd1, 4'd0};
    vecs[13] = '{4'b1000, 1'b0, 2, 1'b0, 1'b0, 2'd1, 4'd0};
    vecs[14] = '{4'b1000, 1'b0, 1, 1'b0, 1'b1, 2'd1, 4'd1};
    vecs[15] = '{4'b0000, 1'b0, 3, 1'b0, 1'b0, 2'd0, 4'd1};
    vecs[16] = '{4'b0001, 1'b0, 5, 1'b0, 1'b0, 2'd0, 4'd1};
    vecs[17] = '{4'b0011, 1'b0, 3, 1'b0, 1'b1, 2'd0, 4'd2};
    vecs[18] = '{4'b0000, 1'b0, 3, 1'b0, 1'b0, 2'd0, 4'd2};

    code  = {4'b0100, 4'b0010, 4'b0001};
    sw    = 4'b0000;
    clr   = 1'b0;
    rst_n = 1'b0;
    tick(2);
    chk("reset", 1'b0, 1'b0, 2'd0, 4'd0);
    rst_n = 1'b1;
    tick(2);

    // Open, ignore input while open, clr, wrong press, partial overlap
    for (int i = 0; i < NVEC; i++) begin
      sw  = vecs[i].sw;
      clr = vecs[i].clr;
      tick(vecs[i].ncyc);
      chk($sformatf("vec%0d", i), vecs[i].ul, vecs[i].er, vecs[i].st, vecs[i].fc);
    end
    clr = 1'b0;

    // Repeated failures saturate the fail count at 15
    exp_fc = 2;
    for (int i = 0; i < 17; i++) begin
      sw = 4'b0011;
      tick(3);
      exp_fc = (exp_fc < 15) ? exp_fc + 1 : 15;
      chk($sformatf("sat%0d", i), 1'b0, 1'b1, 2'd0, 4'(exp_fc));
      sw = 4'b0000;
      tick(3);
    end
    chk("sat_armed", 1'b0, 1'b0, 2'd0, 4'd15);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("sat_clr", 1'b0, 1'b0, 2'd0, 4'd0);

    // Glitch shorter than a clock period between edges is never captured
    sw = 4'b0001;
    #3;
    sw = 4'b0000;
    tick(5);
    chk("glitch", 1'b0, 1'b0, 2'd0, 4'd0);
    sw = 4'b0001;
    tick(3);
    sw = 4'b0000;
    tick(3);
    chk("press3", 1'b0, 1'b0, 2'd1, 4'd0);

    // Idle at step 1
`ifdef SEQ_LOCK_TIMEOUT_EN
    tick(15);
    chk("tmo_before", 1'b0, 1'b0, 2'd1, 4'd0);
    tick(1);
    chk("tmo_err", 1'b0, 1'b1, 2'd1, 4'd1);
    tick(1);
    chk("tmo_exit", 1'b0, 1'b0, 2'd0, 4'd1);
`else
    tick(20);
    chk("no_tmo", 1'b0, 1'b0, 2'd1, 4'd0);
`endif

    // Asynchronous reset in the middle of the last step
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    do_step(4'b0001);
    do_step(4'b0010);
    sw = 4'b0100;
    tick(5);
    chk("held_s2", 1'b0, 1'b0, 2'd2, 4'd0);
    #2;
    rst_n = 1'b0;
    sw    = 4'b0000;
    #1;
    chk("async_rst", 1'b0, 1'b0, 2'd0, 4'd0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst", 1'b0, 1'b0, 2'd0, 4'd0);
    sw = 4'b0100;
    tick(5);
    chk("post_rst_wrong", 1'b0, 1'b1, 2'd0, 4'd1);
    sw = 4'b0000;
    tick(3);
    do_step(4'b0001);
    do_step(4'b0010);
    do_step(4'b0100);
    chk("reopen", 1'b1, 1'b0, 2'd2, 4'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
